// File: rtl/mips_regfile_pkg.sv
// mips_regfile_pkg
// Shared types and sizing helpers for the parametrised MIPS register file.
//   rf_state_t : bulk-clear sequencer states (RF_IDLE, RF_CLEAR)
//   addr_w_f   : address width for a given register count
//   part_w_f   : display slice-select width for a given data/slice width
package mips_regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    function automatic int addr_w_f(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // At least one bit even when the word is a single slice wide.
    function automatic int part_w_f(input int data_w, input int disp_w);
        int nparts;
        nparts = data_w / disp_w;
        return (nparts <= 1) ? 1 : $clog2(nparts);
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq
// Bulk-clear sequencer: once started, walks an index from 0 to DEPTH-1,
// asserting a clear-write strobe for one entry per clock.
// Ports:
//   CLK      in  clock (rising edge)
//   reset    in  asynchronous active-low reset
//   clr_req  in  start request, sampled while idle
//   clr_busy out high while clearing (registered)
//   clr_we   out clear-write strobe for entry clr_idx
//   clr_idx  out entry being cleared on the coming edge
module rf_clear_seq
    import mips_regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              busy_reg;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= RF_IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_reg <= RF_CLEAR;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // clr_req is deliberately ignored here; a request still
                    // high on the first idle edge starts a fresh clear.
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= RF_IDLE;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= RF_IDLE;
                    idx_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = busy_reg;
    assign clr_we   = busy_reg;
    assign clr_idx  = idx_reg;

endmodule

// File: rtl/mips_regfile_p.sv
// mips_regfile_p
// Parametrised register file for the multicycle MIPS core.
// Ports:
//   CLK, reset            clock, asynchronous active-low reset
//   RegW, DR, Reg_In      CPU write port (entry 0 is read-only zero)
//   SR1, SR2              read addresses
//   ReadReg1, ReadReg2    registered read data (optional write-through)
//   in_en, in_val         switch injection into entry IN_REG
//   disp_sel, disp_part   display tap register / slice select
//   DisplayReg            combinational display slice
//   clr_req, clr_busy     bulk-clear request / in-progress flag
module mips_regfile_p
    import mips_regfile_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    parameter  int IN_REG = 1,
    parameter  int IN_W   = 3,
    parameter  int DISP_W = 16,
    parameter  int BYPASS = 1,
    localparam int ADDR_W = addr_w_f(DEPTH),
    localparam int NPART  = DATA_W / DISP_W,
    localparam int PART_W = part_w_f(DATA_W, DISP_W)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              RegW,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] Reg_In,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    output logic [DATA_W-1:0] ReadReg1,
    output logic [DATA_W-1:0] ReadReg2,
    input  logic              in_en,
    input  logic [IN_W-1:0]   in_val,
    input  logic [ADDR_W-1:0] disp_sel,
    input  logic [PART_W-1:0] disp_part,
    output logic [DISP_W-1:0] DisplayReg,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam logic [ADDR_W-1:0] IN_ADDR = ADDR_W'(IN_REG);
    localparam int                NSLOT   = 1 << PART_W;

    logic [DATA_W-1:0] regs_reg  [DEPTH];
    logic [DATA_W-1:0] regs_next [DEPTH];
    logic [DATA_W-1:0] rd1_reg, rd2_reg;
    logic [DATA_W-1:0] rd1_next, rd2_next;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              cpu_we;
    logic              inj_we;
    logic [DATA_W-1:0] inj_data;

    rf_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .CLK      (CLK),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // Write sources only act while idle. A CPU write to the injection
    // register suppresses the injection so exactly one value lands there.
    assign inj_data = DATA_W'(in_val);
    assign cpu_we   = !clr_busy && RegW && (DR != '0);
    assign inj_we   = !clr_busy && in_en && !(cpu_we && (DR == IN_ADDR));

    always_comb begin
        regs_next = regs_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_we && (clr_idx == ADDR_W'(i))) begin
                regs_next[i] = '0;
            end else if (cpu_we && (DR == ADDR_W'(i))) begin
                regs_next[i] = Reg_In;
            end else if (inj_we && (IN_ADDR == ADDR_W'(i))) begin
                regs_next[i] = inj_data;
            end
        end
        regs_next[0] = '0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            regs_reg <= regs_next;
        end
    end

    // Write-through: the CPU write is checked first because it already
    // has priority over injection on a shared index. Entry 0 never
    // forwards since neither write strobe can target it.
    always_comb begin
        rd1_next = regs_reg[SR1];
        rd2_next = regs_reg[SR2];
        if (BYPASS != 0) begin
            if (cpu_we && (DR == SR1)) begin
                rd1_next = Reg_In;
            end else if (inj_we && (IN_ADDR == SR1)) begin
                rd1_next = inj_data;
            end
            if (cpu_we && (DR == SR2)) begin
                rd2_next = Reg_In;
            end else if (inj_we && (IN_ADDR == SR2)) begin
                rd2_next = inj_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd1_reg <= '0;
            rd2_reg <= '0;
        end else if (clr_busy) begin
            rd1_reg <= '0;
            rd2_reg <= '0;
        end else begin
            rd1_reg <= rd1_next;
            rd2_reg <= rd2_next;
        end
    end

    assign ReadReg1 = rd1_reg;
    assign ReadReg2 = rd2_reg;

    // Display tap: slice table padded to a power of two so that
    // out-of-range selects fall on zero entries.
    logic [DATA_W-1:0] disp_word;
    logic [DISP_W-1:0] disp_slots [NSLOT];

    assign disp_word = regs_reg[disp_sel];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_disp
            if (gi < NPART) begin : g_live
                assign disp_slots[gi] = disp_word[gi*DISP_W +: DISP_W];
            end else begin : g_pad
                assign disp_slots[gi] = '0;
            end
        end
    endgenerate

    assign DisplayReg = disp_slots[disp_part];

endmodule

// File: tb/tb_mips_regfile_p.sv
// tb_mips_regfile_p
// Self-checking bench for mips_regfile_p (default parameters, BYPASS=1).
// Read results are predicted from a reference model when stimulus is
// driven, queued, and compared after the DUT edge.
module tb_mips_regfile_p;

    logic        CLK;
    logic        reset;
    logic        RegW;
    logic [4:0]  DR;
    logic [31:0] Reg_In;
    logic [4:0]  SR1, SR2;
    logic [31:0] ReadReg1, ReadReg2;
    logic        in_en;
    logic [2:0]  in_val;
    logic [4:0]  disp_sel;
    logic [0:0]  disp_part;
    logic [15:0] DisplayReg;
    logic        clr_req;
    logic        clr_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [32];
    logic [31:0] exp_q [$];

    mips_regfile_p #(
        .DATA_W (32),
        .DEPTH  (32),
        .IN_REG (1),
        .IN_W   (3),
        .DISP_W (16),
        .BYPASS (1)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .RegW       (RegW),
        .DR         (DR),
        .Reg_In     (Reg_In),
        .SR1        (SR1),
        .SR2        (SR2),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .in_en      (in_en),
        .in_val     (in_val),
        .disp_sel   (disp_sel),
        .disp_part  (disp_part),
        .DisplayReg (DisplayReg),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // One idle-state transaction: drive, predict, clock, compare.
    task automatic cycle(input logic regw, input logic [4:0] dr, input logic [31:0] din,
                         input logic [4:0] sr1, input logic [4:0] sr2,
                         input logic inen, input logic [2:0] inval, input string tag);
        logic        cpu, inj;
        logic [31:0] e1, e2, ival;
        RegW = regw; DR = dr; Reg_In = din; SR1 = sr1; SR2 = sr2;
        in_en = inen; in_val = inval;
        ival = {29'h0, inval};
        cpu  = regw && (dr != 5'd0);
        inj  = inen && !(cpu && dr == 5'd1);
        e1 = (cpu && dr == sr1) ? din : (inj && sr1 == 5'd1) ? ival : mdl[sr1];
        e2 = (cpu && dr == sr2) ? din : (inj && sr2 == 5'd1) ? ival : mdl[sr2];
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        if (inj) mdl[1] = ival;
        if (cpu) mdl[dr] = din;
        @(posedge CLK); #1;
        check_val({tag, ".rd1"}, ReadReg1, exp_q.pop_front());
        check_val({tag, ".rd2"}, ReadReg2, exp_q.pop_front());
        RegW = 1'b0; in_en = 1'b0;
    endtask

    task automatic idle_inputs();
        RegW = 1'b0; DR = '0; Reg_In = '0; SR1 = '0; SR2 = '0;
        in_en = 1'b0; in_val = '0; clr_req = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] v;
        idle_inputs();
        disp_sel = 5'd5; disp_part = 1'b0;
        model_clear();
        reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst.rd1", ReadReg1, 32'h0);
        check_val("rst.rd2", ReadReg2, 32'h0);
        check_val("rst.busy", {31'h0, clr_busy}, 32'h0);
        check_val("rst.disp", {16'h0, DisplayReg}, 32'h0);
        reset = 1'b1;

        // Write then read back one edge later.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 3'd0, "wr5");
        cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 3'd0, "rd5");
        check_val("disp5", {16'h0, DisplayReg}, 32'h0000BEEF);

        // Asynchronous reset clears outputs without a clock edge.
        #2 reset = 1'b0;
        #1;
        check_val("arst.rd1", ReadReg1, 32'h0);
        check_val("arst.disp", {16'h0, DisplayReg}, 32'h0);
        model_clear();
        #1 reset = 1'b1;
        @(posedge CLK); #1;

        // Register 0 is hardwired zero.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 3'd0, "r0wr");
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 3'd0, "r0rd");

        // Same-edge write-through.
        cycle(1'b1, 5'd7, 32'h00001234, 5'd0, 5'd7, 1'b0, 3'd0, "byp7");
        cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 3'd0, "rd7");

        // Injection, then injection overridden by a CPU write to reg 1.
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b1, 3'b101, "inj");
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 1'b0, 3'd0, "injrd");
        cycle(1'b1, 5'd1, 32'd9, 5'd1, 5'd2, 1'b1, 3'b101, "injpri");
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 1'b0, 3'd0, "pri_rd");

        // Display tap slices.
        cycle(1'b1, 5'd3, 32'hAABBCCDD, 5'd0, 5'd0, 1'b0, 3'd0, "wr3");
        disp_sel = 5'd3; disp_part = 1'b1; #1;
        check_val("disp.hi", {16'h0, DisplayReg}, 32'h0000AABB);
        disp_part = 1'b0; #1;
        check_val("disp.lo", {16'h0, DisplayReg}, 32'h0000CCDD);
        @(posedge CLK); #1;

        // Random idle traffic against the model.
        for (int i = 0; i < 30; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rnd");
        end

        // Fill every register, then bulk clear with a write attempted mid-clear.
        for (int i = 1; i < 32; i++) begin
            cycle(1'b1, 5'(i), 32'h01010101 * i ^ 32'h5A5A5A5A, 5'(i), 5'd0, 1'b0, 3'd0, "fill");
        end
        clr_req = 1'b1;
        @(posedge CLK); #1;
        clr_req = 1'b0;
        check_val("clr.start", {31'h0, clr_busy}, 32'h1);
        RegW = 1'b1; DR = 5'd9; Reg_In = 32'h77777777; in_en = 1'b1; in_val = 3'd6;
        n = 0;
        while (clr_busy && n < 100) begin
            @(posedge CLK); #1;
            n++;
            check_val("clr.rd1", ReadReg1, 32'h0);
        end
        check_val("clr.len", 32'(n), 32'd32);
        idle_inputs();
        model_clear();
        for (int i = 0; i < 32; i++) begin
            disp_sel = 5'(i);
            disp_part = 1'b0; #1;
            v[15:0] = DisplayReg;
            disp_part = 1'b1; #1;
            v[31:16] = DisplayReg;
            check_val("clr.reg", v, 32'h0);
        end
        @(posedge CLK); #1;
        cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd1, 1'b0, 3'd0, "clr.drop");

        // Reset in the middle of a clear.
        for (int i = 15; i < 25; i++) begin
            cycle(1'b1, 5'(i), 32'hC0DE0000 + i, 5'd0, 5'd0, 1'b0, 3'd0, "fill2");
        end
        clr_req = 1'b1;
        @(posedge CLK); #1;
        clr_req = 1'b0;
        repeat (10) @(posedge CLK);
        #2 reset = 1'b0;
        #1;
        check_val("mid.busy", {31'h0, clr_busy}, 32'h0);
        disp_sel = 5'd20; disp_part = 1'b0; #1;
        check_val("mid.disp", {16'h0, DisplayReg}, 32'h0);
        model_clear();
        @(negedge CLK) reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_val("mid.idle", {31'h0, clr_busy}, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 5'd20, 5'd24, 1'b0, 3'd0, "mid.rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
